// File: rtl/serial_mant_mult_ctrl.sv
// Bit-serial shift-and-add significand multiplier sequencer. One external
// 1-bit full adder is time-shared across every bit of every partial product.
module serial_mant_mult_ctrl #(
    parameter int W  = 24,
    parameter int CW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy,
    output logic           fa_a,
    output logic           fa_b,
    output logic           fa_ci,
    input  logic           fa_s,
    input  logic           fa_co
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_reg_q, a_reg_d;
    logic [W-1:0]   acc_hi_q, acc_hi_d;
    logic [W-1:0]   acc_lo_q, acc_lo_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  pos_q, pos_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_reg_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            carry_q   <= 1'b0;
            pos_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_reg_q   <= a_reg_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            carry_q   <= carry_d;
            pos_q     <= pos_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // acc_lo starts as the multiplier and is consumed LSB-first while the
    // product's low half shifts in from acc_hi, so {acc_hi, acc_lo} ends exact.
    always_comb begin
        state_d   = state_q;
        a_reg_d   = a_reg_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        carry_d   = carry_q;
        pos_d     = pos_q;
        bit_cnt_d = bit_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_ci     = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    a_reg_d   = a_in;
                    acc_hi_d  = '0;
                    acc_lo_d  = b_in;
                    carry_d   = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                if (acc_lo_q[0]) begin
                    pos_d   = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            ADD: begin
                fa_a            = acc_hi_q[pos_q];
                fa_b            = a_reg_q[pos_q];
                fa_ci           = carry_q;
                acc_hi_d[pos_q] = fa_s;
                carry_d         = fa_co;
                pos_d           = pos_q + 1'b1;
                if (pos_q == CW'(W-1))
                    state_d = SHIFT;
            end
            SHIFT: begin
                // Final adder carry becomes the new MSB of the high half.
                acc_hi_d = {carry_q, acc_hi_q[W-1:1]};
                acc_lo_d = {acc_hi_q[0], acc_lo_q[W-1:1]};
                carry_d  = 1'b0;
                if (bit_cnt_q == CW'(W-1)) begin
                    state_d = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = EVAL;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign product = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_serial_mant_mult_ctrl.sv
// Randomized self-checking bench: external full adder modelled here, results
// compared against plain multiplication and the b-popcount latency rule.
module tb_serial_mant_mult_ctrl;

    localparam int W  = 24;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           fa_a, fa_b, fa_ci;
    logic           fa_s, fa_co;

    int n_tests = 0;
    int n_fail  = 0;

    serial_mant_mult_ctrl #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy),
        .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
        .fa_s(fa_s), .fa_co(fa_co)
    );

    assign {fa_co, fa_s} = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_ci};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operand pair, wait for the product, optionally stall the
    // consumer (with ignored in_valid pulses), then complete the handshake.
    task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall, input bit watch_fa, input bit pulse);
        logic [2*W-1:0] exp_p;
        int exp_lat, lat, fa_hits;
        logic [2*W-1:0] held;
        exp_p   = 48'({24'b0, a} * {24'b0, b});
        exp_lat = 2*W + W*$countones(b);
        fa_hits = 0;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; a_in = a; b_in = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom);
        chk({tag, "_busy"}, 64'({busy, in_ready}), 64'b10);
        lat = 0;
        while (!out_valid && lat < 2000) begin
            if (watch_fa && (fa_a || fa_b || fa_ci)) fa_hits++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_prod"}, 64'(product), 64'(exp_p));
        if (watch_fa) chk({tag, "_fa"}, 64'(fa_hits), 64'd0);
        if (stall > 0) begin
            held = product;
            for (int i = 0; i < stall; i++) begin
                in_valid = pulse ? i[0] : 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk({tag, "_hold"}, 64'({product, out_valid, in_ready}), 64'({held, 2'b10}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel"}, 64'({out_valid, in_ready, busy}), 64'b010);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int k;
        #7;
        chk("rst_state", 64'({in_ready, out_valid, busy, fa_a, fa_b, fa_ci}), 64'b100000);
        chk("rst_prod", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("t15x15", 24'hC00000, 24'hC00000, 0, 1'b0, 1'b0);
        run_txn("tzero", 24'hABCDEF, 24'h000000, 0, 1'b1, 1'b0);
        run_txn("tmax", 24'hFFFFFF, 24'hFFFFFF, 0, 1'b0, 1'b0);
        run_txn("tbp", 24'hC00000, 24'hC00000, 10, 1'b0, 1'b1);
        run_txn("tb2b", 24'h800001, 24'h800000, 0, 1'b0, 1'b0);

        // Asynchronous reset while the adder is mid-ADD.
        @(negedge clk);
        in_valid = 1'b1; a_in = 24'hFFFFFF; b_in = 24'hFFFFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (99) @(posedge clk);
        #2;
        chk("pre_arst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", 64'({busy, in_ready, out_valid}), 64'b010);
        chk("arst_prod", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("tpost", 24'h800000, 24'h800000, 0, 1'b0, 1'b0);

        // Random mix: sparse multipliers keep the run short, dense ones and
        // corner values exercise long carry chains.
        for (int n = 0; n < 150; n++) begin
            k  = int'($urandom_range(0, 9));
            ra = W'($urandom);
            rb = (k < 6) ? W'($urandom & $urandom) : W'($urandom);
            if (k == 7) ra = 24'hFFFFFF;
            if (k == 8) rb = 24'hFFFFFF;
            if (k == 9) ra = '0;
            run_txn("rand", ra, rb, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
